// File: rtl/ysyx_23060025_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_rd_arbiter
//
// Two-master to one-slave arbiter for the AXI-lite read channels (AR and R).
// Master 0 is the IFU instruction fetch port and master 1 is the LSU load
// port. Both share the single read port in front of the crossbar. Only one
// read is outstanding at a time. Write channels do not pass through here.
//
// A transaction walks IDLE -> ADDR -> DATA -> IDLE:
//   IDLE : pick a master (round-robin when both request). No AR is driven,
//          so arbitration costs exactly one cycle.
//   ADDR : granted master's AR channel is wired through to the slave.
//   DATA : slave R channel is wired through to the granted master.
// The grant is frozen from IDLE until the R handshake completes.
//
// Ports
//   clock, rstn               : clock, asynchronous active-low reset
//   m0_ar_* / m0_r_*          : IFU read address / read data channels
//   m1_ar_* / m1_r_*          : LSU read address / read data channels
//   s_ar_* / s_r_*            : shared slave read address / read data channels
// Parameters
//   DATA_LEN : read data width
//   ADDR_LEN : address width
// ---------------------------------------------------------------------------
module ysyx_23060025_rd_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,

  // Master 0 (IFU)
  input  logic [ADDR_LEN-1:0] m0_ar_addr_i,
  input  logic                m0_ar_valid_i,
  output logic                m0_ar_ready_o,
  input  logic [2:0]          m0_ar_size_i,
  output logic [DATA_LEN-1:0] m0_r_data_o,
  output logic [1:0]          m0_r_resp_o,
  output logic                m0_r_valid_o,
  input  logic                m0_r_ready_i,

  // Master 1 (LSU)
  input  logic [ADDR_LEN-1:0] m1_ar_addr_i,
  input  logic                m1_ar_valid_i,
  output logic                m1_ar_ready_o,
  input  logic [2:0]          m1_ar_size_i,
  output logic [DATA_LEN-1:0] m1_r_data_o,
  output logic [1:0]          m1_r_resp_o,
  output logic                m1_r_valid_o,
  input  logic                m1_r_ready_i,

  // Slave
  output logic [ADDR_LEN-1:0] s_ar_addr_o,
  output logic                s_ar_valid_o,
  input  logic                s_ar_ready_i,
  output logic [2:0]          s_ar_size_o,
  input  logic [DATA_LEN-1:0] s_r_data_i,
  input  logic [1:0]          s_r_resp_i,
  input  logic                s_r_valid_i,
  output logic                s_r_ready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b11
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_grant;       // 0 = m0 owns the slave, 1 = m1
  logic   r_last_grant;  // owner of the most recently completed read
  logic   w_grant_nxt;
  logic   w_r_done;      // R handshake completes this cycle

  // -------------------------------------------------------------------------
  // State register. Reset leaves last_grant=1 so m0 wins the first tie, and
  // drops any in-flight transaction: from IDLE nothing is forwarded.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      if (w_r_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state, grant decision and channel muxing.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_r_done      = 1'b0;

    m0_ar_ready_o = 1'b0;
    m0_r_data_o   = '0;
    m0_r_resp_o   = 2'b00;
    m0_r_valid_o  = 1'b0;
    m1_ar_ready_o = 1'b0;
    m1_r_data_o   = '0;
    m1_r_resp_o   = 2'b00;
    m1_r_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_ar_valid_o  = 1'b0;
    s_ar_size_o   = 3'b000;
    s_r_ready_o   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (m0_ar_valid_i || m1_ar_valid_i) begin
          // On a tie the master that did not win last time goes next;
          // otherwise the lone requester wins.
          if (m0_ar_valid_i && m1_ar_valid_i) begin
            w_grant_nxt = ~r_last_grant;
          end else begin
            w_grant_nxt = m1_ar_valid_i;
          end
          w_state_nxt = ADDR;
        end
      end

      ADDR: begin
        if (r_grant) begin
          s_ar_valid_o  = m1_ar_valid_i;
          s_ar_addr_o   = m1_ar_addr_i;
          s_ar_size_o   = m1_ar_size_i;
          m1_ar_ready_o = s_ar_ready_i;
        end else begin
          s_ar_valid_o  = m0_ar_valid_i;
          s_ar_addr_o   = m0_ar_addr_i;
          s_ar_size_o   = m0_ar_size_i;
          m0_ar_ready_o = s_ar_ready_i;
        end
        // If the granted master withdraws its request we simply wait here;
        // the grant is never re-arbitrated mid-transaction.
        if (s_ar_valid_o && s_ar_ready_i) begin
          w_state_nxt = DATA;
        end
      end

      DATA: begin
        if (r_grant) begin
          m1_r_valid_o = s_r_valid_i;
          m1_r_data_o  = s_r_data_i;
          m1_r_resp_o  = s_r_resp_i;
          s_r_ready_o  = m1_r_ready_i;
        end else begin
          m0_r_valid_o = s_r_valid_i;
          m0_r_data_o  = s_r_data_i;
          m0_r_resp_o  = s_r_resp_i;
          s_r_ready_o  = m0_r_ready_i;
        end
        // Single-beat reads: one R handshake closes the transaction.
        if (s_r_valid_i && s_r_ready_o) begin
          w_r_done    = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060025_rd_arbiter.
//
// Background processes model the two masters (request queues) and the slave
// (configurable AR/R wait states and response code). Each request pushes its
// expected grant order and read result into scoreboard queues; a monitor pops
// and compares whenever the DUT completes an AR or R handshake. Inputs change
// at posedge+1, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_rd_arbiter;

  localparam int DL = 32;
  localparam int AL = 32;

  logic          clock = 1'b0;
  logic          rstn;

  logic [AL-1:0] m0_ar_addr_i;
  logic          m0_ar_valid_i;
  logic          m0_ar_ready_o;
  logic [2:0]    m0_ar_size_i;
  logic [DL-1:0] m0_r_data_o;
  logic [1:0]    m0_r_resp_o;
  logic          m0_r_valid_o;
  logic          m0_r_ready_i;
  logic [AL-1:0] m1_ar_addr_i;
  logic          m1_ar_valid_i;
  logic          m1_ar_ready_o;
  logic [2:0]    m1_ar_size_i;
  logic [DL-1:0] m1_r_data_o;
  logic [1:0]    m1_r_resp_o;
  logic          m1_r_valid_o;
  logic          m1_r_ready_i;
  logic [AL-1:0] s_ar_addr_o;
  logic          s_ar_valid_o;
  logic          s_ar_ready_i;
  logic [2:0]    s_ar_size_o;
  logic [DL-1:0] s_r_data_i;
  logic [1:0]    s_r_resp_i;
  logic          s_r_valid_i;
  logic          s_r_ready_o;

  always #5 clock = ~clock;

  ysyx_23060025_rd_arbiter #(.DATA_LEN(DL), .ADDR_LEN(AL)) dut (
    .clock         (clock),
    .rstn          (rstn),
    .m0_ar_addr_i  (m0_ar_addr_i),
    .m0_ar_valid_i (m0_ar_valid_i),
    .m0_ar_ready_o (m0_ar_ready_o),
    .m0_ar_size_i  (m0_ar_size_i),
    .m0_r_data_o   (m0_r_data_o),
    .m0_r_resp_o   (m0_r_resp_o),
    .m0_r_valid_o  (m0_r_valid_o),
    .m0_r_ready_i  (m0_r_ready_i),
    .m1_ar_addr_i  (m1_ar_addr_i),
    .m1_ar_valid_i (m1_ar_valid_i),
    .m1_ar_ready_o (m1_ar_ready_o),
    .m1_ar_size_i  (m1_ar_size_i),
    .m1_r_data_o   (m1_r_data_o),
    .m1_r_resp_o   (m1_r_resp_o),
    .m1_r_valid_o  (m1_r_valid_o),
    .m1_r_ready_i  (m1_r_ready_i),
    .s_ar_addr_o   (s_ar_addr_o),
    .s_ar_valid_o  (s_ar_valid_o),
    .s_ar_ready_i  (s_ar_ready_i),
    .s_ar_size_o   (s_ar_size_o),
    .s_r_data_i    (s_r_data_i),
    .s_r_resp_i    (s_r_resp_i),
    .s_r_valid_i   (s_r_valid_i),
    .s_r_ready_o   (s_r_ready_o)
  );

  // All DUT outputs packed together for the reset-is-all-zero comparisons.
  logic [108:0] all_outs;
  assign all_outs = {m0_ar_ready_o, m0_r_data_o, m0_r_resp_o, m0_r_valid_o,
                     m1_ar_ready_o, m1_r_data_o, m1_r_resp_o, m1_r_valid_o,
                     s_ar_addr_o, s_ar_valid_o, s_ar_size_o, s_r_ready_o};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        m;
    logic [31:0] addr;
  } ar_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  ar_exp_t     ar_q[$];
  r_exp_t      exp_q0[$];
  r_exp_t      exp_q1[$];
  logic [31:0] req_q0[$];
  logic [31:0] req_q1[$];

  int total = 0;
  int bad   = 0;

  // Slave knobs
  typedef enum {SL_AR, SL_RW, SL_R} sl_ph_e;
  sl_ph_e      sl_ph      = SL_AR;
  int          sl_ar_wait = 0;
  int          sl_r_wait  = 0;
  int          sl_cnt     = 0;
  logic [1:0]  sl_resp    = 2'b00;
  bit          slave_en   = 1'b1;
  logic [31:0] sl_addr;

  localparam logic [2:0] M0_SIZE = 3'd2;
  localparam logic [2:0] M1_SIZE = 3'd1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h3000_0000) return 32'h0000_0413;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Queue a read for master m; the call order of push_req is the expected
  // order in which the slave sees the AR handshakes.
  task automatic push_req(input logic m, input logic [31:0] a);
    ar_exp_t x;
    r_exp_t  e;
    x.m    = m;
    x.addr = a;
    e.data = mem_data(a);
    e.resp = sl_resp;
    ar_q.push_back(x);
    if (m) begin
      req_q1.push_back(a);
      exp_q1.push_back(e);
    end else begin
      req_q0.push_back(a);
      exp_q0.push_back(e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Master models
  // ---------------------------------------------------------------------------
  logic hs0, hs1;

  initial begin : master0
    m0_ar_valid_i = 1'b0;
    m0_ar_addr_i  = '0;
    m0_ar_size_i  = M0_SIZE;
    forever begin
      @(negedge clock);
      hs0 = m0_ar_valid_i && m0_ar_ready_o;
      @(posedge clock);
      #1;
      if (!rstn) begin
        m0_ar_valid_i = 1'b0;
      end else if (hs0 || !m0_ar_valid_i) begin
        if (req_q0.size() > 0) begin
          m0_ar_addr_i  = req_q0.pop_front();
          m0_ar_valid_i = 1'b1;
        end else begin
          m0_ar_valid_i = 1'b0;
          m0_ar_addr_i  = '0;
        end
      end
    end
  end

  initial begin : master1
    m1_ar_valid_i = 1'b0;
    m1_ar_addr_i  = '0;
    m1_ar_size_i  = M1_SIZE;
    forever begin
      @(negedge clock);
      hs1 = m1_ar_valid_i && m1_ar_ready_o;
      @(posedge clock);
      #1;
      if (!rstn) begin
        m1_ar_valid_i = 1'b0;
      end else if (hs1 || !m1_ar_valid_i) begin
        if (req_q1.size() > 0) begin
          m1_ar_addr_i  = req_q1.pop_front();
          m1_ar_valid_i = 1'b1;
        end else begin
          m1_ar_valid_i = 1'b0;
          m1_ar_addr_i  = '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slave model: s_ar_ready rises sl_ar_wait cycles after AR valid is seen,
  // R valid rises sl_r_wait cycles after the AR handshake.
  // ---------------------------------------------------------------------------
  logic        sv_arv, sv_arhs, sv_rhs;
  logic [31:0] sv_addr;

  task automatic drive_r();
    s_r_valid_i = 1'b1;
    s_r_data_i  = mem_data(sl_addr);
    s_r_resp_i  = sl_resp;
    sl_ph       = SL_R;
  endtask

  initial begin : slave
    s_ar_ready_i = 1'b1;
    s_r_valid_i  = 1'b0;
    s_r_data_i   = '0;
    s_r_resp_i   = 2'b00;
    forever begin
      @(negedge clock);
      sv_arv  = s_ar_valid_o;
      sv_arhs = s_ar_valid_o && s_ar_ready_i;
      sv_rhs  = s_r_valid_i && s_r_ready_o;
      sv_addr = s_ar_addr_o;
      @(posedge clock);
      #1;
      if (slave_en) begin
        case (sl_ph)
          SL_AR: begin
            if (sv_arhs) begin
              s_ar_ready_i = 1'b0;
              sl_addr      = sv_addr;
              sl_cnt       = sl_r_wait;
              if (sl_cnt == 0) drive_r();
              else sl_ph = SL_RW;
            end else begin
              if (!sv_arv) sl_cnt = sl_ar_wait;
              else if (sl_cnt > 0) sl_cnt--;
              s_ar_ready_i = (sl_cnt == 0);
            end
          end
          SL_RW: begin
            sl_cnt--;
            if (sl_cnt == 0) drive_r();
          end
          SL_R: begin
            if (sv_rhs) begin
              s_r_valid_i  = 1'b0;
              s_r_data_i   = '0;
              s_r_resp_i   = 2'b00;
              sl_ph        = SL_AR;
              sl_cnt       = sl_ar_wait;
              s_ar_ready_i = (sl_cnt == 0);
            end
          end
          default: sl_ph = SL_AR;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares every handshake about to complete at the next posedge.
  // ---------------------------------------------------------------------------
  ar_exp_t mon_ar;
  r_exp_t  mon_r;

  always @(negedge clock) begin
    if (rstn) begin
      if (s_ar_valid_o && s_ar_ready_i) begin
        total++;
        if (ar_q.size() == 0) begin
          bad++;
          $display("FAIL ar_unexpected: got addr=%h, required no AR", s_ar_addr_o);
        end else begin
          mon_ar = ar_q.pop_front();
          if (s_ar_addr_o !== mon_ar.addr ||
              {m1_ar_ready_o, m0_ar_ready_o} !== (mon_ar.m ? 2'b10 : 2'b01) ||
              s_ar_size_o !== (mon_ar.m ? M1_SIZE : M0_SIZE)) begin
            bad++;
            $display("FAIL ar_order: got addr=%h rdy{m1,m0}=%b size=%0d, required addr=%h master=%0d",
                     s_ar_addr_o, {m1_ar_ready_o, m0_ar_ready_o}, s_ar_size_o,
                     mon_ar.addr, mon_ar.m);
          end
        end
      end
      if (m0_r_valid_o && m0_r_ready_i) begin
        total++;
        if (exp_q0.size() == 0) begin
          bad++;
          $display("FAIL r0_unexpected: got data=%h, required no response", m0_r_data_o);
        end else begin
          mon_r = exp_q0.pop_front();
          if (m0_r_data_o !== mon_r.data || m0_r_resp_o !== mon_r.resp || m1_r_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL r0_data: got data=%h resp=%b m1_valid=%b, required data=%h resp=%b m1_valid=0",
                     m0_r_data_o, m0_r_resp_o, m1_r_valid_o, mon_r.data, mon_r.resp);
          end
        end
      end
      if (m1_r_valid_o && m1_r_ready_i) begin
        total++;
        if (exp_q1.size() == 0) begin
          bad++;
          $display("FAIL r1_unexpected: got data=%h, required no response", m1_r_data_o);
        end else begin
          mon_r = exp_q1.pop_front();
          if (m1_r_data_o !== mon_r.data || m1_r_resp_o !== mon_r.resp || m0_r_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL r1_data: got data=%h resp=%b m0_valid=%b, required data=%h resp=%b m0_valid=0",
                     m1_r_data_o, m1_r_resp_o, m0_r_valid_o, mon_r.data, mon_r.resp);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic wait_drain(input string tag);
    int n = 0;
    while ((ar_q.size() + exp_q0.size() + exp_q1.size() + req_q0.size() + req_q1.size()) != 0
           && n < 300) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_timeout: got pending ar=%0d r0=%0d r1=%0d, required all 0",
               tag, ar_q.size(), exp_q0.size(), exp_q1.size());
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    rstn = 1'b1;

    // Park an m0 read in DATA with the slave holding R valid.
    m0_r_ready_i = 1'b0;
    push_req(1'b0, 32'h3000_0040);
    n = 0;
    while (!m0_r_valid_o && n < 50) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (m0_r_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_reach_data: got m0_r_valid=%b, required 1", m0_r_valid_o);
    end
    slave_en = 1'b0;

    // Assert reset between clock edges: outputs must clear immediately.
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_async: got %h, required 0", all_outs);
    end
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_hold: got %h, required 0", all_outs);
    end
    @(negedge clock);
    rstn = 1'b1;
    exp_q0.delete();
    m0_r_ready_i = 1'b1;

    // Stale slave R valid must not leak to either master.
    repeat (3) begin
      @(negedge clock);
      total++;
      if ({m0_r_valid_o, m1_r_valid_o, s_r_ready_o, s_ar_valid_o} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_stale: got {r0v,r1v,srr,sarv}=%b, required 0000",
                 {m0_r_valid_o, m1_r_valid_o, s_r_ready_o, s_ar_valid_o});
      end
    end
    s_r_valid_i  = 1'b0;
    s_r_data_i   = '0;
    s_r_resp_i   = 2'b00;
    sl_cnt       = 0;
    sl_ph        = SL_AR;
    s_ar_ready_i = 1'b1;
    slave_en     = 1'b1;
  endtask

  task automatic test_m0_only();
    int n = 0;
    sl_ar_wait = 0;
    sl_r_wait  = 0;
    sl_resp    = 2'b00;
    push_req(1'b0, 32'h3000_0000);
    while (!m0_ar_valid_i && n < 20) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (s_ar_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL m0_ar_idle: got s_ar_valid=%b, required 0", s_ar_valid_o);
    end
    @(negedge clock);
    total++;
    if (s_ar_valid_o !== 1'b1 || s_ar_addr_o !== 32'h3000_0000) begin
      bad++;
      $display("FAIL m0_ar_latency: got valid=%b addr=%h, required valid=1 addr=30000000",
               s_ar_valid_o, s_ar_addr_o);
    end
    @(negedge clock);
    total++;
    if (m0_r_valid_o !== 1'b1 || m0_r_data_o !== 32'h0000_0413 || m1_r_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL m0_rdata: got r0v=%b data=%h r1v=%b, required r0v=1 data=00000413 r1v=0",
               m0_r_valid_o, m0_r_data_o, m1_r_valid_o);
    end
    @(negedge clock);
    total++;
    if (m0_r_valid_o !== 1'b0 || m1_r_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL m0_done: got r0v=%b r1v=%b, required 0 0", m0_r_valid_o, m1_r_valid_o);
    end
    wait_drain("m0_only");
  endtask

  task automatic test_round_robin();
    apply_reset();
    push_req(1'b0, 32'h3000_0004);
    push_req(1'b1, 32'h8000_0010);
    push_req(1'b0, 32'h3000_0008);
    push_req(1'b1, 32'h8000_0014);
    push_req(1'b0, 32'h3000_000C);
    push_req(1'b1, 32'h8000_0018);
    wait_drain("round_robin");
  endtask

  task automatic test_stall();
    int  n        = 0;
    int  ar_stall = 0;
    int  r_wait   = 0;
    bit  done     = 1'b0;
    sl_ar_wait = 5;
    sl_r_wait  = 4;
    push_req(1'b0, 32'h3000_0100);
    @(negedge clock);
    push_req(1'b1, 32'h8000_0100);
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
      if (m0_r_valid_o && m0_r_ready_i) done = 1'b1;
      total++;
      if (m1_ar_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_m1_ready: got %b, required 0", m1_ar_ready_o);
      end
      if (s_ar_valid_o) begin
        total++;
        if (s_ar_addr_o !== 32'h3000_0100) begin
          bad++;
          $display("FAIL stall_addr: got %h, required 30000100", s_ar_addr_o);
        end
        if (!s_ar_ready_i) ar_stall++;
      end
      if (s_r_ready_o && !s_r_valid_i) r_wait++;
    end
    sl_ar_wait = 0;
    sl_r_wait  = 0;
    total++;
    if (!done || ar_stall != 5 || r_wait != 4) begin
      bad++;
      $display("FAIL stall_counts: got done=%0d ar_stall=%0d r_wait=%0d, required 1 5 4",
               done, ar_stall, r_wait);
    end
    wait_drain("stall");
  endtask

  task automatic test_backpressure();
    int n = 0;
    m1_r_ready_i = 1'b0;
    push_req(1'b1, 32'h8000_0020);
    while (!m1_r_valid_o && n < 50) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      total++;
      if (s_r_ready_o !== 1'b0 || m1_r_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: got s_r_ready=%b m1_r_valid=%b, required 0 1",
                 i, s_r_ready_o, m1_r_valid_o);
      end
    end
    @(posedge clock);
    #1;
    m1_r_ready_i = 1'b1;
    @(negedge clock);
    total++;
    if (s_r_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got s_r_ready=%b, required 1", s_r_ready_o);
    end
    @(negedge clock);
    total++;
    if (m1_r_valid_o !== 1'b0 || s_r_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_exit: got m1_r_valid=%b s_r_ready=%b, required 0 0",
               m1_r_valid_o, s_r_ready_o);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_error();
    sl_resp = 2'b10;
    push_req(1'b1, 32'h8000_0200);
    wait_drain("error");
    sl_resp = 2'b00;
    // m1 finished last, so a tie now goes to m0.
    push_req(1'b0, 32'h3000_0200);
    push_req(1'b1, 32'h8000_0204);
    wait_drain("error_next");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rstn         = 1'b0;
    m0_r_ready_i = 1'b1;
    m1_r_ready_i = 1'b1;
    test_reset();
    test_m0_only();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
